// File: rtl/axi_hp_burst_responder_if.sv
// AXI3 64-bit burst channel bundle between the ADC/DAC DMA masters and the
// HP-port stand-in memory. Signal names follow the AXI channel names.
interface axi_hp_burst_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [3:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [2:0]            awprot;
    logic [3:0]            awcache;
    logic                  awvalid;
    logic                  awready;
    logic [63:0]           wdata;
    logic [7:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [2:0]            arprot;
    logic [3:0]            arcache;
    logic                  arvalid;
    logic                  arready;
    logic [63:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awprot, awcache, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output araddr, arlen, arsize, arburst, arprot, arcache, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awprot, awcache, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  araddr, arlen, arsize, arburst, arprot, arcache, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_hp_burst_responder.sv
// AXI3 64-bit burst slave backed by a byte-enabled memory. Terminates the ADC
// DMA write master and the DAC DMA read master; independent write and read
// FSMs share one dual-port memory (read-first on same-word collisions).
module axi_hp_burst_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h00000000)
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    axi_hp_burst_responder_if.slave   s_axi
);
    // One spare index bit so a burst running past the top never wraps to word 0.
    localparam int                IDX_W     = ADDR_WIDTH - 2;
    localparam int                MEM_AW    = $clog2(MEM_WORDS);
    localparam logic [IDX_W-1:0]  MEM_LIMIT = IDX_W'(MEM_WORDS);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [1:0]        RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 3);
    endfunction

    // Only 8-byte beats and FIXED/INCR bursts are supported.
    function automatic logic req_error(input logic [1:0] burst, input logic [2:0] size);
        return (size != 3'd3) || burst[1];
    endfunction

    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx, input logic [1:0] burst);
        return (burst == 2'b01) ? idx + IDX_W'(1) : idx;
    endfunction

    function automatic logic [1:0] beat_resp(input logic err, input logic oor);
        return oor ? RESP_DECERR : (err ? RESP_SLVERR : RESP_OKAY);
    endfunction

    // DECERR dominates SLVERR dominates OKAY.
    function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
        if ((a == RESP_DECERR) || (b == RESP_DECERR)) begin
            return RESP_DECERR;
        end else if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) begin
            return RESP_SLVERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

    logic [63:0] mem_r [MEM_WORDS];

    w_state_t         w_state_r, w_state_s;
    logic [IDX_W-1:0] w_idx_r, w_idx_s;
    logic [3:0]       w_len_r, w_len_s;
    logic [1:0]       w_burst_r, w_burst_s;
    logic             w_err_r, w_err_s;
    logic [4:0]       w_beat_r, w_beat_s;
    logic [1:0]       w_acc_r, w_acc_s;
    logic [1:0]       bresp_r, bresp_s;
    logic             awready_r, wready_r, bvalid_r;
    logic             w_oor_s, w_last_err_s, mem_we_s;
    logic [1:0]       w_beat_resp_s;

    r_state_t         r_state_r, r_state_s;
    logic [IDX_W-1:0] r_idx_r, r_idx_s, r_cur_idx_s;
    logic [3:0]       r_len_r, r_len_s, r_beat_r, r_beat_s;
    logic [1:0]       r_burst_r, r_burst_s, r_cur_burst_s;
    logic             r_err_r, r_err_s, r_cur_err_s, r_cur_last_s, r_cur_oor_s, r_load_s;
    logic             arready_r, rvalid_r, rvalid_s, rlast_r, rlast_s;
    logic [63:0]      rdata_r, rdata_s;
    logic [1:0]       rresp_r, rresp_s;

    logic unused_sideband_s;
    assign unused_sideband_s = ^{s_axi.awprot, s_axi.awcache, s_axi.arprot, s_axi.arcache};

    assign s_axi.awready = awready_r;
    assign s_axi.wready  = wready_r;
    assign s_axi.bvalid  = bvalid_r;
    assign s_axi.bresp   = bresp_r;
    assign s_axi.arready = arready_r;
    assign s_axi.rvalid  = rvalid_r;
    assign s_axi.rlast   = rlast_r;
    assign s_axi.rdata   = rdata_r;
    assign s_axi.rresp   = rresp_r;

    // Write FSM next-state, per-beat response accumulation and memory write enable.
    always_comb begin
        w_state_s     = w_state_r;
        w_idx_s       = w_idx_r;
        w_len_s       = w_len_r;
        w_burst_s     = w_burst_r;
        w_err_s       = w_err_r;
        w_beat_s      = w_beat_r;
        w_acc_s       = w_acc_r;
        bresp_s       = bresp_r;
        mem_we_s      = 1'b0;
        w_oor_s       = (w_idx_r >= MEM_LIMIT);
        w_last_err_s  = s_axi.wlast && (w_beat_r != {1'b0, w_len_r});
        w_beat_resp_s = merge_resp(beat_resp(w_err_r, w_oor_s),
                                   w_last_err_s ? RESP_SLVERR : RESP_OKAY);
        case (w_state_r)
            W_IDLE: begin
                if (s_axi.awvalid) begin
                    w_state_s = W_DATA;
                    w_idx_s   = word_index(s_axi.awaddr);
                    w_len_s   = s_axi.awlen;
                    w_burst_s = s_axi.awburst;
                    w_err_s   = req_error(s_axi.awburst, s_axi.awsize);
                    w_beat_s  = 5'd0;
                    w_acc_s   = RESP_OKAY;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_DATA: begin
                if (s_axi.wvalid) begin
                    mem_we_s = !w_err_r && !w_oor_s && (w_beat_r <= {1'b0, w_len_r});
                    w_acc_s  = merge_resp(w_acc_r, w_beat_resp_s);
                    w_idx_s  = next_index(w_idx_r, w_burst_r);
                    w_beat_s = (w_beat_r == 5'd31) ? w_beat_r : w_beat_r + 5'd1;
                    if (s_axi.wlast) begin
                        w_state_s = W_RESP;
                        bresp_s   = w_acc_s;
                    end else begin
                        w_state_s = W_DATA;
                    end
                end else begin
                    w_state_s = W_DATA;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: begin
                w_state_s = W_IDLE;
            end
        endcase
    end

    // Write FSM state and registered AW/W/B handshake outputs.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_r <= W_IDLE;
            w_idx_r   <= '0;
            w_len_r   <= 4'd0;
            w_burst_r <= 2'b00;
            w_err_r   <= 1'b0;
            w_beat_r  <= 5'd0;
            w_acc_r   <= RESP_OKAY;
            bresp_r   <= RESP_OKAY;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            w_idx_r   <= w_idx_s;
            w_len_r   <= w_len_s;
            w_burst_r <= w_burst_s;
            w_err_r   <= w_err_s;
            w_beat_r  <= w_beat_s;
            w_acc_r   <= w_acc_s;
            bresp_r   <= bresp_s;
            awready_r <= (w_state_s == W_IDLE);
            wready_r  <= (w_state_s == W_DATA);
            bvalid_r  <= (w_state_s == W_RESP);
        end
    end

    // Byte-enabled memory write port; contents survive reset.
    always_ff @(posedge axi_aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem_r[w_idx_r[MEM_AW-1:0]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM next-state and next beat selection (new request or advance after handshake).
    always_comb begin
        r_state_s     = r_state_r;
        r_idx_s       = r_idx_r;
        r_len_s       = r_len_r;
        r_burst_s     = r_burst_r;
        r_err_s       = r_err_r;
        r_beat_s      = r_beat_r;
        rvalid_s      = rvalid_r;
        rlast_s       = rlast_r;
        rdata_s       = rdata_r;
        rresp_s       = rresp_r;
        r_load_s      = 1'b0;
        r_cur_idx_s   = r_idx_r;
        r_cur_err_s   = r_err_r;
        r_cur_burst_s = r_burst_r;
        r_cur_last_s  = (r_beat_r == r_len_r);
        case (r_state_r)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    r_state_s     = R_DATA;
                    r_load_s      = 1'b1;
                    r_cur_idx_s   = word_index(s_axi.araddr);
                    r_cur_err_s   = req_error(s_axi.arburst, s_axi.arsize);
                    r_cur_burst_s = s_axi.arburst;
                    r_cur_last_s  = (s_axi.arlen == 4'd0);
                    r_len_s       = s_axi.arlen;
                    r_burst_s     = s_axi.arburst;
                    r_err_s       = r_cur_err_s;
                    r_beat_s      = 4'd1;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    if (rlast_r) begin
                        r_state_s = R_IDLE;
                        rvalid_s  = 1'b0;
                        rlast_s   = 1'b0;
                    end else begin
                        r_load_s = 1'b1;
                        r_beat_s = r_beat_r + 4'd1;
                    end
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: begin
                r_state_s = R_IDLE;
                rvalid_s  = 1'b0;
                rlast_s   = 1'b0;
            end
        endcase
        r_cur_oor_s = (r_cur_idx_s >= MEM_LIMIT);
        if (r_load_s) begin
            rvalid_s = 1'b1;
            rlast_s  = r_cur_last_s;
            rresp_s  = beat_resp(r_cur_err_s, r_cur_oor_s);
            rdata_s  = (r_cur_err_s || r_cur_oor_s) ? 64'd0 : mem_r[r_cur_idx_s[MEM_AW-1:0]];
            r_idx_s  = next_index(r_cur_idx_s, r_cur_burst_s);
        end else begin
            rresp_s = rresp_r;
        end
    end

    // Read FSM state and registered AR/R outputs; rdata is captured before any same-cycle write lands.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state_r <= R_IDLE;
            r_idx_r   <= '0;
            r_len_r   <= 4'd0;
            r_burst_r <= 2'b00;
            r_err_r   <= 1'b0;
            r_beat_r  <= 4'd0;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= 64'd0;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_s;
            r_idx_r   <= r_idx_s;
            r_len_r   <= r_len_s;
            r_burst_r <= r_burst_s;
            r_err_r   <= r_err_s;
            r_beat_r  <= r_beat_s;
            arready_r <= (r_state_s == R_IDLE);
            rvalid_r  <= rvalid_s;
            rlast_r   <= rlast_s;
            rdata_r   <= rdata_s;
            rresp_r   <= rresp_s;
        end
    end
endmodule

// File: tb/tb_axi_hp_burst_responder.sv
// Directed bench for axi_hp_burst_responder: stimulus tasks push expected
// B/R responses into queues; negedge monitors compare whenever the DUT
// presents bvalid/rvalid (peeking while stalled, popping on handshake).
module tb_axi_hp_burst_responder;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_mis;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t     rq[$];
    logic [1:0] bq[$];

    axi_hp_burst_responder_if #(.ADDR_WIDTH(32)) bus ();

    axi_hp_burst_responder #(
        .ADDR_WIDTH(32),
        .MEM_WORDS (1024),
        .BASE_ADDR (32'h00000000)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .s_axi      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a ready (0=awready,1=wready,2=arready) with a cycle budget.
    task automatic wait_hs(input int which, input string name);
        logic hs;
        int   n;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = (which == 0) ? bus.awready : ((which == 1) ? bus.wready : bus.arready);
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s_timeout: no handshake after %0d cycles, required 1", name, n);
        end
    endtask

    // B monitor: compare bresp against the scoreboard whenever bvalid is shown.
    always @(negedge clk) begin
        if (rst_n && bus.bvalid) begin
            if (bq.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL b_unexpected: bresp %b with none expected", bus.bresp);
            end else begin
                chk("bresp", 64'(bus.bresp), 64'(bq[0]));
                if (bus.bready) void'(bq.pop_front());
            end
        end
    end

    // R monitor: compare each presented beat; a stalled beat is re-checked every cycle.
    always @(negedge clk) begin
        if (rst_n && bus.rvalid) begin
            if (rq.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL r_unexpected: rdata 0x%h with none expected", bus.rdata);
            end else begin
                chk("rdata", bus.rdata, rq[0].data);
                chk("rresp", 64'(bus.rresp), 64'(rq[0].resp));
                chk("rlast", 64'(bus.rlast), 64'(rq[0].last));
                if (bus.rready) void'(rq.pop_front());
            end
        end
    end

    task automatic push_r(input logic [63:0] d, input logic [1:0] r, input logic l);
        rbeat_t b;
        b.data = d;
        b.resp = r;
        b.last = l;
        rq.push_back(b);
    endtask

    // Write burst: beat i carries base*(i+1); wlast on the final beat sent.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input int nbeats, input logic [63:0] base,
                            input logic [7:0] strb, input logic [1:0] exp_resp);
        int n;
        bq.push_back(exp_resp);
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awburst = burst;
        bus.awsize  = size;
        bus.awvalid = 1'b1;
        wait_hs(0, "aw");
        bus.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.wdata  = base * 64'(i + 1);
            bus.wstrb  = strb;
            bus.wlast  = (i == nbeats - 1);
            bus.wvalid = 1'b1;
            wait_hs(1, "w");
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk("bvalid_after_wlast", 64'(bus.bvalid), 64'd1);
        n = 0;
        while (bq.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("b_drained", 64'(bq.size()), 64'd0);
    endtask

    // Read burst; expected beats already queued. rpat drives rready per cycle after AR.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] rpat, input logic chk_lat);
        int k;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arburst = burst;
        bus.arsize  = size;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        wait_hs(2, "ar");
        bus.arvalid = 1'b0;
        chk("rvalid_first_beat", 64'(bus.rvalid), 64'd1);
        k = 0;
        while (rq.size() != 0 && k < 100) begin
            bus.rready = (k < 8) ? rpat[k] : 1'b1;
            tick();
            k++;
        end
        bus.rready = 1'b1;
        chk("r_drained", 64'(rq.size()), 64'd0);
        if (chk_lat) chk("r_beats_cycles", 64'(k), 64'(len) + 64'd1);
        chk("rvalid_after_rlast", 64'(bus.rvalid), 64'd0);
        chk("arready_after_rlast", 64'(bus.arready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_mis = 0;
        rst_n = 1'b0;
        bus.awaddr = 32'd0; bus.awlen = 4'd0; bus.awsize = 3'd3; bus.awburst = 2'b01;
        bus.awprot = 3'd0; bus.awcache = 4'd0; bus.awvalid = 1'b0;
        bus.wdata = 64'd0; bus.wstrb = 8'h00; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = 32'd0; bus.arlen = 4'd0; bus.arsize = 3'd3; bus.arburst = 2'b01;
        bus.arprot = 3'd0; bus.arcache = 4'd0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_awready", 64'(bus.awready), 64'd1);
        chk("rst_arready", 64'(bus.arready), 64'd1);
        chk("rst_wready",  64'(bus.wready),  64'd0);
        chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
        chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
        chk("rst_rlast",   64'(bus.rlast),   64'd0);
        chk("rst_rdata",   bus.rdata,        64'd0);

        // 4-beat INCR write then read back.
        do_write(32'h100, 4'd3, 2'b01, 3'd3, 4, 64'h11, 8'hFF, 2'b00);
        push_r(64'h11, 2'b00, 1'b0);
        push_r(64'h22, 2'b00, 1'b0);
        push_r(64'h33, 2'b00, 1'b0);
        push_r(64'h44, 2'b00, 1'b1);
        do_read(32'h100, 4'd3, 2'b01, 3'd3, 8'hFF, 1'b1);

        // Byte strobes: only the low four bytes are overwritten.
        do_write(32'h0, 4'd0, 2'b01, 3'd3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00);
        do_write(32'h0, 4'd0, 2'b01, 3'd3, 1, 64'h0, 8'h0F, 2'b00);
        push_r(64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1);
        do_read(32'h0, 4'd0, 2'b01, 3'd3, 8'hFF, 1'b1);

        // Top-of-memory: beat 1 runs past the last word.
        do_write(32'h1FF8, 4'd1, 2'b01, 3'd3, 2, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b11);
        push_r(64'h0123_4567_89AB_CDEF, 2'b00, 1'b0);
        push_r(64'h0, 2'b11, 1'b1);
        do_read(32'h1FF8, 4'd1, 2'b01, 3'd3, 8'hFF, 1'b1);

        // WRAP burst is rejected and leaves memory untouched; early wlast errors.
        do_write(32'h100, 4'd1, 2'b10, 3'd3, 2, 64'hAA, 8'hFF, 2'b10);
        push_r(64'h11, 2'b00, 1'b0);
        push_r(64'h22, 2'b00, 1'b1);
        do_read(32'h100, 4'd1, 2'b01, 3'd3, 8'hFF, 1'b1);
        do_write(32'h200, 4'd3, 2'b01, 3'd3, 2, 64'h5, 8'hFF, 2'b10);

        // FIXED burst: every beat targets the same word, last one wins.
        do_write(32'h300, 4'd2, 2'b00, 3'd3, 3, 64'h1, 8'hFF, 2'b00);
        push_r(64'h3, 2'b00, 1'b0);
        push_r(64'h3, 2'b00, 1'b1);
        do_read(32'h300, 4'd1, 2'b00, 3'd3, 8'hFF, 1'b1);

        // Size errors and out-of-range reads; DECERR wins over SLVERR.
        do_write(32'h100, 4'd0, 2'b01, 3'd2, 1, 64'h99, 8'hFF, 2'b10);
        push_r(64'h0, 2'b10, 1'b1);
        do_read(32'h100, 4'd0, 2'b01, 3'd2, 8'hFF, 1'b1);
        push_r(64'h0, 2'b11, 1'b1);
        do_read(32'h2000, 4'd0, 2'b01, 3'd2, 8'hFF, 1'b1);
        push_r(64'h0, 2'b11, 1'b1);
        do_read(32'h2000, 4'd0, 2'b01, 3'd3, 8'hFF, 1'b1);

        // rready 1,0,0,1: stalled beat must hold steady, order preserved.
        push_r(64'h11, 2'b00, 1'b0);
        push_r(64'h22, 2'b00, 1'b0);
        push_r(64'h33, 2'b00, 1'b0);
        push_r(64'h44, 2'b00, 1'b1);
        do_read(32'h100, 4'd3, 2'b01, 3'd3, 8'b1111_1001, 1'b0);

        // Reset in the middle of a stalled read.
        push_r(64'h11, 2'b00, 1'b0);
        bus.rready  = 1'b0;
        bus.araddr  = 32'h100;
        bus.arlen   = 4'd3;
        bus.arburst = 2'b01;
        bus.arsize  = 3'd3;
        bus.arvalid = 1'b1;
        wait_hs(2, "ar_mid");
        bus.arvalid = 1'b0;
        repeat (2) tick();
        rq.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("midrst_rlast",  64'(bus.rlast),  64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bus.rready = 1'b1;
        tick();
        chk("post_rst_arready", 64'(bus.arready), 64'd1);
        chk("post_rst_awready", 64'(bus.awready), 64'd1);

        // Memory survives reset.
        push_r(64'h11, 2'b00, 1'b1);
        do_read(32'h100, 4'd0, 2'b01, 3'd3, 8'hFF, 1'b1);
        push_r(64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1);
        do_read(32'h0, 4'd0, 2'b01, 3'd3, 8'hFF, 1'b1);

        repeat (3) tick();
        chk("rq_empty_end", 64'(rq.size()), 64'd0);
        chk("bq_empty_end", 64'(bq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/axi_hp_burst_responder.md
Name: axi_hp_burst_responder

Overview:
- AXI3 64-bit burst slave that terminates the ADC DMA write master (`adc_m_dest_axi_*`) and the DAC DMA read master (`dac_m_src_axi_*`).
- Backed by an internal byte-enabled memory.
- Used as the HP-port stand-in for PL-only simulation and for loopback bring-up: the ADC DMA writes buffers that the DAC DMA reads back.
- Write and read channels are independent FSMs sharing one dual-port memory.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- MEM_WORDS, 1024, number of 64-bit words; power of two.
- BASE_ADDR, 32'h00000000, byte address mapped to word 0.

Ports:
- axi_aclk  in  1  single clock for all logic
- axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address
- s_axi_awlen  in  4  beats-1
- s_axi_awsize  in  3  beat size
- s_axi_awburst  in  2  burst type
- s_axi_awprot  in  3  ignored
- s_axi_awcache  in  4  ignored
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  64  write data
- s_axi_wstrb  in  8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_araddr  in  ADDR_WIDTH  read burst start byte address
- s_axi_arlen  in  4  beats-1
- s_axi_arsize  in  3  beat size
- s_axi_arburst  in  2  burst type
- s_axi_arprot  in  3  ignored
- s_axi_arcache  in  4  ignored
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rdata  out  64  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready

Behaviour:
- Reset is asynchronous on axi_aresetn low. Outputs on reset:
  - awready=1, arready=1
  - wready=0, bvalid=0, rvalid=0, rlast=0
  - bresp=0, rresp=0, rdata=0
  - Memory contents are not reset.
- Burst decode, same for AW and AR:
  - Word index = (addr-BASE_ADDR)>>3. Addr bits [2:0] are ignored.
  - Burst types:
    - INCR (01): index+1 per beat.
    - FIXED (00): index held for all beats.
    - WRAP (10) and 11: error.
  - size!=3: error.
  - Any beat with index >= MEM_WORDS is out of range; index never wraps.
  - Response codes: error → SLVERR (2'b10); out of range → DECERR (2'b11). If both apply, DECERR wins.
- Write FSM: W_IDLE → W_DATA → W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch addr/len/burst, clear beat counter and error flag, go to W_DATA. awready=0 from the next cycle.
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb to mem[index], then advances the index.
    - A write is suppressed if the beat is errored, out of range, or beat count > awlen.
    - wlast on beat != awlen sets SLVERR.
    - On the wlast handshake, go to W_RESP.
  - W_RESP: bvalid=1 with the accumulated bresp, held stable until bready. On the handshake, go to W_IDLE with awready=1 the next cycle.
  - Throughput: one beat per cycle with wvalid held high.
- Read FSM: R_IDLE → R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch the request and go to R_DATA. rvalid=1 with beat 0 on the following cycle, so first-beat latency is 1 cycle after the AR handshake.
  - R_DATA:
    - rdata/rresp/rlast are held stable while rvalid && !rready.
    - On a handshake, the next beat is presented in the next cycle, so rvalid stays high: one beat per cycle with rready held high.
    - rlast=1 exactly on beat arlen.
  - An errored or out-of-range beat returns rdata=0 with the corresponding rresp; in-range beats of the same burst return OKAY.
  - On the rlast handshake, go to R_IDLE: rvalid=0 and arready=1 the next cycle.
- Collisions: a read and a write to the same word in the same cycle return the old data (read-first).
- Reset mid-burst aborts both FSMs to IDLE. Memory writes already committed remain.

Test Plan:
- Reset release, no traffic → awready=1, arready=1, wready=0, bvalid=0, rvalid=0.
- AW addr 0x100, len 3, INCR, size 3; 4 beats 0x11..0x44, wstrb=0xFF, wlast on beat 3, bready=1 → bresp=00 one cycle after wlast. Then AR addr 0x100, len 3 → rdata 0x11,0x22,0x33,0x44 on consecutive cycles, rlast on the 4th beat, rresp=00.
- Write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then 0x0 with wstrb=0x0F, len 0 → read of 0x0 returns 0xFFFF_FFFF_0000_0000.
- AR len 1 starting at the last word (MEM_WORDS-1)*8 → beat0 rresp=00, beat1 rdata=0 with rresp=11.
- AW with burst=10 (WRAP), len 1 → both beats accepted, memory unchanged, bresp=10. AW len 3 with wlast on beat 1 → bresp=10.
- rready toggled 1,0,0,1 during a 4-beat read → rdata/rlast stable while stalled, beat order preserved. Assert axi_aresetn low mid-read → rvalid=0 immediately and arready=1 after release.
